// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch-flush, multiply and
// memory-stall hold/flush/bubble generation plus a stall-cycle counter.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_memread_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic [4:0]       IFID_rs_i,
    input  logic [4:0]       IFID_rt_i,
    input  logic             branch_taken_i,
    input  logic             mul_start_i,
    input  logic             mem_stall_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             ex_hold_o,
    output logic             mem_freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        MUL = 2'd1,
        MEM = 2'd2
    } state_t;

    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    state_t     eff;
    logic [3:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic luh;
    logic pc_hold, ifid_hold, ifid_flush;
    logic idex_bubble, ex_hold, mem_freeze;

    assign luh = IDEX_memread_i
               & (IDEX_rd_i != 5'd0)
               & ((IDEX_rd_i == IFID_rs_i) | (IDEX_rd_i == IFID_rt_i));

    // Leaving MEM re-applies the rules of the interrupted state in the
    // same cycle, so the freeze costs no extra cycle.
    assign eff = (state_q == MEM) ? saved_q : state_q;

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mem_freeze  = 1'b0;
        state_d     = state_q;
        saved_d     = saved_q;
        cnt_d       = cnt_q;
        priority case (1'b1)
            mem_stall_i: begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                mem_freeze = 1'b1;
                state_d    = MEM;
                if (state_q != MEM)
                    saved_d = state_q;
            end
            (eff == MUL): begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                ex_hold   = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = MUL;
                end
            end
            luh: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d    = RUN;
                ifid_flush = branch_taken_i;
                if (mul_start_i) begin
                    state_d = MUL;
                    cnt_d   = MUL_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_q <= '0;
        else if (pc_hold_o && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign pc_hold_o      = rst_i & pc_hold;
    assign ifid_hold_o    = rst_i & ifid_hold;
    assign ifid_flush_o   = rst_i & ifid_flush;
    assign idex_bubble_o  = rst_i & idex_bubble;
    assign ex_hold_o      = rst_i & ex_hold;
    assign mem_freeze_o   = rst_i & mem_freeze;
    assign state_o        = state_q;
    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed steps push expected vectors,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             IDEX_memread_i;
    logic [4:0]       IDEX_rd_i;
    logic [4:0]       IFID_rs_i;
    logic [4:0]       IFID_rt_i;
    logic             branch_taken_i;
    logic             mul_start_i;
    logic             mem_stall_i;
    logic             pc_hold_o;
    logic             ifid_hold_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             ex_hold_o;
    logic             mem_freeze_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles_o;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_memread_i (IDEX_memread_i),
        .IDEX_rd_i      (IDEX_rd_i),
        .IFID_rs_i      (IFID_rs_i),
        .IFID_rt_i      (IFID_rt_i),
        .branch_taken_i (branch_taken_i),
        .mul_start_i    (mul_start_i),
        .mem_stall_i    (mem_stall_i),
        .pc_hold_o      (pc_hold_o),
        .ifid_hold_o    (ifid_hold_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .ex_hold_o      (ex_hold_o),
        .mem_freeze_o   (mem_freeze_o),
        .state_o        (state_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [11:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;
    logic done = 1'b0;

    // exp6 = {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, mem_freeze}
    task automatic step(input string name, input logic rst,
                        input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic mul, input logic ms,
                        input logic [5:0] exp6, input logic [1:0] est);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        IDEX_memread_i = mr;
        IDEX_rd_i      = rd;
        IFID_rs_i      = rs;
        IFID_rt_i      = rt;
        branch_taken_i = br;
        mul_start_i    = mul;
        mem_stall_i    = ms;
        if (!rst)
            exp_stall = 0;
        e.name = name;
        e.vec  = {exp6, est, 4'(exp_stall)};
        q.push_back(e);
        if (exp6[5] && exp_stall < 15)
            exp_stall++;
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            e   = q.pop_front();
            act = {pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
                   ex_hold_o, mem_freeze_o, state_o, stall_cycles_o};
            n_cmp++;
            if (act !== e.vec) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, act, e.vec);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: bench did not finish");
            $fatal(1);
        end
    end

    initial begin
        rst_i          = 1'b0;
        IDEX_memread_i = 1'b0;
        IDEX_rd_i      = 5'd0;
        IFID_rs_i      = 5'd0;
        IFID_rt_i      = 5'd0;
        branch_taken_i = 1'b0;
        mul_start_i    = 1'b0;
        mem_stall_i    = 1'b1;
        repeat (2) @(posedge clk_i);

        step("rst_ms",    0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 2'd0);
        step("rel_frz",   1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd0);
        step("mem_exit",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd2);
        step("luh_rs",    1, 1, 5, 5, 0, 0, 0, 0, 6'b110100, 2'd0);
        step("luh_rd0",   1, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);
        step("luh_rt",    1, 1, 7, 3, 7, 0, 0, 0, 6'b110100, 2'd0);
        step("branch",    1, 0, 0, 0, 0, 1, 0, 0, 6'b001000, 2'd0);
        step("br_luh",    1, 1, 5, 5, 0, 1, 0, 0, 6'b110100, 2'd0);
        step("mul_go",    1, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 2'd0);
        step("mul_h1",    1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd1);
        step("mul_h2",    1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd1);
        step("mul_h3",    1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd1);
        step("mul_done",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);
        step("mul_br",    1, 0, 0, 0, 0, 1, 1, 0, 6'b001000, 2'd0);
        step("mul_ign",   1, 1, 5, 5, 0, 1, 0, 0, 6'b110010, 2'd1);
        step("mfrz_1",    1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd1);
        for (int i = 0; i < 4; i++)
            step("mfrz_n", 1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd2);
        step("mul_res",   1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd2);
        step("mul_last",  1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd1);
        step("run_back",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);
        step("sat_luh1",  1, 1, 9, 9, 0, 0, 0, 0, 6'b110100, 2'd0);
        step("sat_luh2",  1, 1, 9, 0, 9, 0, 0, 0, 6'b110100, 2'd0);
        step("sat_idle",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);
        step("sat_ms1",   1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd0);
        step("sat_ms2",   1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd2);
        step("sat_ms3",   1, 0, 0, 0, 0, 0, 0, 1, 6'b110001, 2'd2);
        step("sat_exit",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd2);
        step("mr_go",     1, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 2'd0);
        step("mr_hold",   1, 0, 0, 0, 0, 0, 0, 0, 6'b110010, 2'd1);
        step("mr_rst",    0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);
        step("mr_after",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0);

        @(negedge clk_i);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
